// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a single register-file write port: round-robin between the
// pipeline (A) and long-latency (B) requesters, plus a pending-register scoreboard.
module regfile_wb_arbiter #(
  parameter int XLEN        = 32,
  parameter int INIT_PRIO_B = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  output logic            q_rs1_busy,
  output logic            q_rs2_busy,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     pending
);

  // Handshake: a transfer happens in any cycle where valid && ready; ready is a pure
  // function of the valids, the priority holder and the scoreboard, never of the data.
  logic        prio_b;
  logic        contested;
  logic        a_fire;
  logic        b_fire;
  logic        b_clr;
  logic        iss_set;
  logic [31:0] clr_vec;
  logic [31:0] set_vec;
  logic [31:0] pending_next;

  always_comb begin
    contested = a_valid & b_valid;
    a_ready   = ~rst & a_valid & (~b_valid | ~prio_b);
    b_ready   = ~rst & b_valid & (~a_valid | prio_b);
    a_fire    = a_valid & a_ready;
    b_fire    = b_valid & b_ready;
    b_clr     = b_fire & (b_rd != 5'd0);
    // A register being retired by B this cycle may be reclaimed in the same cycle.
    iss_ready = ~rst & ((iss_rd == 5'd0) | ~pending[iss_rd] | (b_clr & (b_rd == iss_rd)));
    iss_set   = iss_valid & iss_ready & (iss_rd != 5'd0);
    clr_vec   = b_clr ? (32'd1 << b_rd) : 32'd0;
    set_vec   = iss_set ? (32'd1 << iss_rd) : 32'd0;
    pending_next = ((pending & ~clr_vec) | set_vec) & ~32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_b   <= (INIT_PRIO_B != 0);
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= '0;
      pending  <= 32'd0;
    end else begin
      if (contested) prio_b <= ~prio_b;
      rf_we   <= (a_fire & (a_rd != 5'd0)) | (b_fire & (b_rd != 5'd0));
      pending <= pending_next;
      if (a_fire) begin
        rf_waddr <= a_rd;
        rf_wdata <= a_data;
      end else if (b_fire) begin
        rf_waddr <= b_rd;
        rf_wdata <= b_data;
      end
    end
  end

  // The write stage counts as busy until the register file has actually absorbed it.
  always_comb begin
    q_rs1_busy = (q_rs1 != 5'd0) & (pending[q_rs1] | (rf_we & (rf_waddr == q_rs1)));
    q_rs2_busy = (q_rs2 != 5'd0) & (pending[q_rs2] | (rf_we & (rf_waddr == q_rs2)));
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter with a reference model and
// a scoreboard queue of expected register-file writes.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;
  localparam int W    = XLEN + 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            a_valid = 0, b_valid = 0, iss_valid = 0;
  logic            a_ready, b_ready, iss_ready;
  logic [4:0]      a_rd = 0, b_rd = 0, iss_rd = 0, q_rs1 = 0, q_rs2 = 0;
  logic [XLEN-1:0] a_data = 0, b_data = 0;
  logic            q_rs1_busy, q_rs2_busy, rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     pending;

  regfile_wb_arbiter #(.XLEN(XLEN), .INIT_PRIO_B(1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rs1_busy(q_rs1_busy), .q_rs2_busy(q_rs2_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // reference model state
  bit       m_pend[32];
  bit       m_prio_b = 1'b1;
  bit       m_we = 1'b0;
  bit [4:0] m_waddr = 5'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_busy(input bit [4:0] q);
    return (q != 0) && (m_pend[q] || (m_we && m_waddr == q));
  endfunction

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v = 32'd0;
    for (int i = 1; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_prio_b = 1'b1;
    m_we     = 1'b0;
    m_waddr  = 5'd0;
    exp_q.delete();
  endtask

  // driver: apply one cycle of stimulus, check combinational outputs, advance the model
  task automatic drive_cycle(input bit av, input bit [4:0] ard, input bit [31:0] ad,
                             input bit bv, input bit [4:0] brd, input bit [31:0] bd,
                             input bit iv, input bit [4:0] ird,
                             input bit [4:0] q1, input bit [4:0] q2);
    bit ear, ebr, eir, bclr;
    @(negedge clk);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    iss_valid = iv; iss_rd = ird; q_rs1 = q1; q_rs2 = q2;
    #1;
    ear  = av && (!bv || !m_prio_b);
    ebr  = bv && (!av || m_prio_b);
    bclr = ebr && brd != 0;
    eir  = (ird == 0) || !m_pend[ird] || (bclr && brd == ird);
    check("a_ready", a_ready, ear);
    check("b_ready", b_ready, ebr);
    check("iss_ready", iss_ready, eir);
    check("q_rs1_busy", q_rs1_busy, m_busy(q1));
    check("q_rs2_busy", q_rs2_busy, m_busy(q2));
    check("pending", pending, m_pend_vec());
    m_we = 1'b0;
    if (ear && ard != 0) begin exp_q.push_back({ard, ad}); m_we = 1'b1; m_waddr = ard; end
    if (ebr && brd != 0) begin exp_q.push_back({brd, bd}); m_we = 1'b1; m_waddr = brd; end
    if (av && bv) m_prio_b = !m_prio_b;
    if (bclr) m_pend[brd] = 1'b0;
    if (iv && eir && ird != 0) m_pend[ird] = 1'b1;
  endtask

  task automatic idle(input bit [4:0] q1);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, q1, 0);
  endtask

  // monitor: every registered write is popped from the scoreboard and compared
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && rf_we) begin
        if (exp_q.size() == 0) begin
          check("rf_we_unexpected", rf_we, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rf_waddr", rf_waddr, e[W-1:XLEN]);
          check("rf_wdata", rf_wdata, e[XLEN-1:0]);
        end
      end
    end
  end

  initial begin
    model_reset();
    a_valid = 1; b_valid = 1; iss_valid = 1; iss_rd = 5'd3;
    repeat (2) @(posedge clk);
    #2;
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_rf_waddr", rf_waddr, 5'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    check("rst_iss_ready", iss_ready, 1'b0);
    rst = 1'b0;

    // A alone, first cycle after reset
    drive_cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
    idle(5);
    // contention for three cycles: B, A, B
    drive_cycle(1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0);
    drive_cycle(1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0);
    drive_cycle(1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 0);
    // scoreboard life cycle for x7
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    drive_cycle(0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0);
    idle(7);
    idle(7);
    // same-cycle reclaim of x9
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    drive_cycle(0, 0, 0, 1, 9, 32'h99, 1, 9, 9, 0);
    idle(9);
    drive_cycle(0, 0, 0, 1, 9, 32'h9A, 0, 0, 9, 0);
    // zero register
    drive_cycle(1, 0, 32'h5, 0, 0, 0, 1, 0, 0, 0);
    idle(0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive_cycle($urandom_range(0, 1), 5'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 1), 5'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 1), 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end

    // reset mid-operation with x7 and x10 pending
    for (int i = 1; i < 32; i++) drive_cycle(0, 0, 0, 1, 5'(i), 32'(i), 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 10, 0, 0);
    drive_cycle(1, 6, 32'hCAFE, 0, 0, 0, 0, 0, 0, 0);
    check("pre_rst_pending", pending, 32'h00000480);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_rf_we", rf_we, 1'b0);
    check("mid_rst_pending", pending, 32'd0);
    check("mid_rst_a_ready", a_ready, 1'b0);
    check("mid_rst_iss_ready", iss_ready, 1'b0);
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    drive_cycle(1, 12, 32'h1234ABCD, 0, 0, 0, 0, 0, 12, 0);
    idle(12);
    idle(0);
    idle(0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
